ailn_stats_stream: RTL and testbench
====================================

AILN_STATS_STREAM -- requirements
Module: ailn_stats_stream

Interface
REQ-001 SHALL have parameter DW, default 8, meaning element width in bits (unsigned elements).
REQ-002 SHALL have parameter MAX_N, default 256, meaning maximum elements per vector (power of two).
REQ-003 SHALL have localparam CW = clog2(MAX_N)+1, the element-counter width.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port i_start, input, 1 bit: one-cycle pulse that begins a vector; sampled only in IDLE.
REQ-007 SHALL have port i_len, input, CW bits: element count, latched on i_start.
REQ-008 SHALL have port i_inv_n, input, 8 bits: Q0.8 reciprocal of length, latched on i_start.
REQ-009 SHALL have port i_alpha, input, 2 bits: dynamic-compression shift for squaring, latched on i_start.
REQ-010 SHALL have ports i_x (DW bits), i_valid (1 bit) and o_ready (1 bit): the element input handshake.
REQ-011 SHALL have ports o_valid (1 bit), i_ready (1 bit), o_mean (DW bits) and o_var (2*DW bits): the result output handshake.
REQ-012 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, ACC, MEAN, VAR and OUT.
REQ-014 SHALL leave IDLE on i_start: to ACC when i_len>0, otherwise to OUT with o_mean=0 and o_var=0.
REQ-015 SHALL clear the sum, sum-of-squares and element count on i_start.
REQ-016 SHALL clamp a latched i_len greater than MAX_N to MAX_N.
REQ-017 SHALL drive o_ready=1 only in ACC; an element transfers when i_valid and o_ready are both high in the same cycle.
REQ-018 SHALL, per transfer, add x to sum (width DW+CW) and add sq(x) = ((x>>alpha)^2)<<(2*alpha) to sumsq (width 2*DW+CW).
REQ-019 SHALL move ACC to MEAN in the cycle after the transfer that makes the count equal the latched length.
REQ-020 SHALL, in MEAN, compute mean = (sum*inv_n)>>8, saturated to 2^DW-1; truncation, no rounding.
REQ-021 SHALL, in VAR, compute var = ((sumsq*inv_n)>>8) - mean^2, clamped to 0 if negative and saturated to 2^(2*DW)-1.
REQ-022 SHALL enter OUT after VAR; o_valid=1 only in OUT; o_mean and o_var stay stable while o_valid=1 and i_ready=0.
REQ-023 SHALL return OUT to IDLE on o_valid and i_ready both high; the next i_start is accepted in that IDLE cycle at the earliest.
REQ-024 SHALL assert o_valid exactly 3 cycles after the clock edge that accepts the last element.
REQ-025 SHALL assert o_valid 1 cycle after i_start when length is 0.
REQ-026 SHALL ignore i_start outside IDLE, with no effect on the latched parameters or the accumulators.
REQ-027 SHALL ignore i_valid outside ACC; no element is accepted.

Reset
REQ-028 SHALL, when i_rst is high, force the FSM to IDLE immediately, asynchronously, including mid-vector.
REQ-029 SHALL, on reset, clear the accumulators, the count and the latched parameters.
REQ-030 SHALL, on reset, set o_ready, o_valid and o_busy to 0, and o_mean and o_var to 0.
REQ-031 SHALL discard any partial vector on reset; the first i_start after i_rst falls is serviced normally.

Structure
REQ-032 SHALL place the FSM state enum, the default DW and MAX_N, and the Q0.8 fraction width constant 8 in shared package ailn_pkg.
REQ-033 SHALL implement the compressed square sq(x, alpha) as sub-module ailn_sq_comp: combinational, DW-bit input, 2*DW-bit output.

Verification
REQ-034 SHALL cover: len=8, inv_n=32, alpha=0, eight elements all 130 -> o_mean=130, o_var=0.
REQ-035 SHALL cover: len=8, inv_n=32, alpha=0, elements 0,255 alternating -> o_mean=127, o_var=16383; the same vector with alpha=2 -> o_mean=127, o_var=15623.
REQ-036 SHALL cover: len=8 vector with i_valid toggling 50% and i_ready held low 5 cycles in OUT -> same results as REQ-034; results stable while held; o_valid exactly 3 cycles after the last transfer.
REQ-037 SHALL cover: i_rst pulsed after 4 of 8 elements, then a fresh len=8 all-130 vector -> outputs zero during reset; second vector gives o_mean=130, o_var=0.
REQ-038 SHALL cover: i_start with len=0 -> o_valid the next cycle, o_mean=0, o_var=0; and i_start pulsed during ACC -> ignored, result unchanged.

Source files
------------

// File: rtl/ailn_pkg.sv
// -----------------------------------------------------------------------------
// ailn_pkg
//   Shared definitions for the streaming statistics block:
//     - default element width and maximum vector length
//     - Q0.8 reciprocal fraction width
//     - FSM state encoding
//     - latched per-vector configuration struct
// -----------------------------------------------------------------------------
package ailn_pkg;

    localparam int AILN_DW     = 8;    // default element width (unsigned)
    localparam int AILN_MAX_N  = 256;  // default max elements per vector
    localparam int AILN_FRAC_W = 8;    // fraction bits of the Q0.8 reciprocal

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_MEAN,
        ST_VAR,
        ST_OUT
    } ailn_state_e;

    // Per-vector settings captured on start; the length lives separately
    // because its width depends on MAX_N.
    typedef struct packed {
        logic [AILN_FRAC_W-1:0] inv_n;
        logic [1:0]             alpha;
    } ailn_cfg_t;

endpackage

// File: rtl/ailn_sq_comp.sv
// -----------------------------------------------------------------------------
// ailn_sq_comp
//   Combinational compressed square: sq = ((x >> alpha)^2) << (2*alpha).
//   Dropping alpha LSBs before squaring shrinks the multiplier input; the
//   shift back restores magnitude at the cost of low-order precision.
// Ports:
//   x     [DW-1:0]    element value (unsigned)
//   alpha [1:0]       compression shift
//   sq    [2*DW-1:0]  compressed square
// -----------------------------------------------------------------------------
module ailn_sq_comp
    import ailn_pkg::*;
#(
    parameter int DW = AILN_DW
) (
    input  logic [DW-1:0]   x,
    input  logic [1:0]      alpha,
    output logic [2*DW-1:0] sq
);

    logic [DW-1:0]   xs;
    logic [2*DW-1:0] xs_w;
    logic [2*DW-1:0] prod;

    assign xs   = x >> alpha;
    assign xs_w = {{DW{1'b0}}, xs};
    assign prod = xs_w * xs_w;
    // xs < 2^(DW-alpha), so the shifted square always fits in 2*DW bits.
    assign sq   = prod << {alpha, 1'b0};

endmodule

// File: rtl/ailn_stats_stream.sv
// -----------------------------------------------------------------------------
// ailn_stats_stream
//   Streams a vector of unsigned elements, accumulating sum and compressed
//   sum-of-squares, then produces mean = (sum*inv_n)>>8 and
//   var = ((sumsq*inv_n)>>8) - mean^2 (clamped/saturated).
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_start               begin a vector (sampled only in IDLE)
//   i_len [CW-1:0]        element count (clamped to MAX_N)
//   i_inv_n [7:0]         Q0.8 reciprocal of the length
//   i_alpha [1:0]         squaring compression shift
//   i_x, i_valid, o_ready element input handshake (ready only in ACC)
//   o_valid, i_ready      result handshake (valid only in OUT)
//   o_mean [DW-1:0]       mean result
//   o_var [2*DW-1:0]      variance result
//   o_busy                high whenever not IDLE
// -----------------------------------------------------------------------------
module ailn_stats_stream
    import ailn_pkg::*;
#(
    parameter  int DW    = AILN_DW,
    parameter  int MAX_N = AILN_MAX_N,
    localparam int CW    = $clog2(MAX_N) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [CW-1:0]   i_len,
    input  logic [7:0]      i_inv_n,
    input  logic [1:0]      i_alpha,
    input  logic [DW-1:0]   i_x,
    input  logic            i_valid,
    output logic            o_ready,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [DW-1:0]   o_mean,
    output logic [2*DW-1:0] o_var,
    output logic            o_busy
);

    localparam int FW    = AILN_FRAC_W;
    localparam int SUM_W = DW + CW;
    localparam int SSQ_W = 2*DW + CW;

    ailn_state_e      state;
    ailn_cfg_t        cfg;
    logic [CW-1:0]    len_q;
    logic [CW-1:0]    cnt;
    logic [SUM_W-1:0] sum;
    logic [SSQ_W-1:0] sumsq;

    // ---------------------------------------------------------------------
    // Element path
    // ---------------------------------------------------------------------
    logic [2*DW-1:0] x_sq;
    logic [CW-1:0]   len_clamped;
    logic [CW-1:0]   cnt_nxt;
    logic            xfer;

    ailn_sq_comp #(.DW(DW)) u_sq (
        .x     (i_x),
        .alpha (cfg.alpha),
        .sq    (x_sq)
    );

    assign len_clamped = (i_len > CW'(MAX_N)) ? CW'(MAX_N) : i_len;
    assign cnt_nxt     = cnt + CW'(1);
    // o_ready is only ever set in ACC, so it alone qualifies the transfer.
    assign xfer        = i_valid && o_ready;

    // ---------------------------------------------------------------------
    // Result datapath (evaluated from the settled accumulators)
    // ---------------------------------------------------------------------
    logic [SUM_W+FW-1:0] mean_prod;
    logic [SUM_W-1:0]    mean_q;
    logic [DW-1:0]       mean_sat;

    assign mean_prod = {{FW{1'b0}}, sum} * {{SUM_W{1'b0}}, cfg.inv_n};
    assign mean_q    = mean_prod[SUM_W+FW-1:FW];
    assign mean_sat  = (|mean_q[SUM_W-1:DW]) ? {DW{1'b1}} : mean_q[DW-1:0];

    logic [SSQ_W+FW-1:0] var_prod;
    logic [SSQ_W-1:0]    var_q;
    logic [2*DW-1:0]     mean_sq;
    logic [SSQ_W-1:0]    mean_sq_w;
    logic [SSQ_W-1:0]    var_diff;
    logic [2*DW-1:0]     var_sat;

    assign var_prod  = {{FW{1'b0}}, sumsq} * {{SSQ_W{1'b0}}, cfg.inv_n};
    assign var_q     = var_prod[SSQ_W+FW-1:FW];
    // o_mean already holds the saturated mean written in MEAN.
    assign mean_sq   = {{DW{1'b0}}, o_mean} * {{DW{1'b0}}, o_mean};
    assign mean_sq_w = {{CW{1'b0}}, mean_sq};
    assign var_diff  = var_q - mean_sq_w;
    assign var_sat   = (var_q < mean_sq_w)          ? '0 :
                       (|var_diff[SSQ_W-1:2*DW])    ? {(2*DW){1'b1}} :
                                                      var_diff[2*DW-1:0];

    // Truncated fraction bits are intentionally discarded.
    logic unused_frac;
    assign unused_frac = ^{mean_prod[FW-1:0], var_prod[FW-1:0]};

    // ---------------------------------------------------------------------
    // Control FSM with registered handshake outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cfg     <= '0;
            len_q   <= '0;
            cnt     <= '0;
            sum     <= '0;
            sumsq   <= '0;
            o_ready <= 1'b0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_mean  <= '0;
            o_var   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        cfg.inv_n <= i_inv_n;
                        cfg.alpha <= i_alpha;
                        len_q     <= len_clamped;
                        cnt       <= '0;
                        sum       <= '0;
                        sumsq     <= '0;
                        o_mean    <= '0;
                        o_var     <= '0;
                        o_busy    <= 1'b1;
                        if (len_clamped != '0) begin
                            state   <= ST_ACC;
                            o_ready <= 1'b1;
                        end else begin
                            // Empty vector: zero results straight away.
                            state   <= ST_OUT;
                            o_valid <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (xfer) begin
                        sum   <= sum + {{CW{1'b0}}, i_x};
                        sumsq <= sumsq + {{CW{1'b0}}, x_sq};
                        cnt   <= cnt_nxt;
                        if (cnt_nxt == len_q) o_ready <= 1'b0;
                    end
                    // One cycle after the final transfer the count matches.
                    if (cnt == len_q) state <= ST_MEAN;
                end
                ST_MEAN: begin
                    o_mean <= mean_sat;
                    state  <= ST_VAR;
                end
                ST_VAR: begin
                    o_var   <= var_sat;
                    o_valid <= 1'b1;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_ready <= 1'b0;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ailn_stats_stream.sv
// -----------------------------------------------------------------------------
// tb_ailn_stats_stream
//   Directed vectors against a plain-arithmetic model of the statistics,
//   with literal expectations for the documented example vectors.
// -----------------------------------------------------------------------------
module tb_ailn_stats_stream;

    localparam int DW = 8;
    localparam int CW = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [CW-1:0]   len = '0;
    logic [7:0]      inv_n = '0;
    logic [1:0]      alpha = '0;
    logic [DW-1:0]   x = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   mean;
    logic [2*DW-1:0] res_var;
    logic            busy;

    ailn_stats_stream dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_len   (len),
        .i_inv_n (inv_n),
        .i_alpha (alpha),
        .i_x     (x),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_mean  (mean),
        .o_var   (res_var),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    int     vec[$];
    longint exp_mean = -1;
    longint exp_var  = -1;

    task automatic check(input string nm, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // Statistics straight from the definitions, over the elements in vec.
    task automatic model(input int a, input int inv);
        longint s, q, xv, xs, m, v;
        s = 0;
        q = 0;
        foreach (vec[k]) begin
            xv = vec[k];
            xs = xv >> a;
            s += xv;
            q += (xs * xs) << (2 * a);
        end
        m = (s * inv) >> 8;
        if (m > 255) m = 255;
        v = ((q * inv) >> 8) - m * m;
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
        exp_mean = m;
        exp_var  = v;
    endtask

    // Whenever a result is offered it must match the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("mean", mean, exp_mean);
            check("var", res_var, exp_var);
        end
    end

    task automatic fill_const(input int n, input int val);
        vec.delete();
        repeat (n) vec.push_back(val);
    endtask

    task automatic fill_alt();
        vec.delete();
        for (int k = 0; k < 8; k++) vec.push_back((k % 2) ? 255 : 0);
    endtask

    // Entered and left at a falling edge with the DUT idle.
    task automatic run_vec(input int len_in, input int inv, input int a,
                           input bit toggle, input int hold, input bit inject,
                           input longint lit_m, input longint lit_v);
        int   idx;
        int   cyc;
        int   w;
        logic v;
        model(a, inv);
        start = 1'b1;
        len   = CW'(len_in);
        inv_n = 8'(inv);
        alpha = 2'(a);
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs so only latched values can be in use.
        len   = 9'h1F3;
        inv_n = 8'h5A;
        alpha = 2'd3;
        check("busy_after_start", busy, 1);
        check("ready_after_start", in_ready, 1);
        idx = 0;
        cyc = 0;
        while (idx < vec.size() && cyc < 2000) begin
            v        = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_valid = v;
            x        = v ? 8'(vec[idx]) : 8'hA5;
            start    = inject && (cyc == 3);
            if (start) len = 9'd2;
            if (v && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 2000) begin
            total++;
            bad++;
            $display("FAIL elem_timeout: got %0d of %0d elements", idx, vec.size());
        end
        // Extra offered data after the last transfer must be ignored.
        in_valid = 1'b1;
        x        = 8'hFF;
        check("ready_low_after_last", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            check("valid_early", out_valid, 0);
            @(negedge clk);
        end
        check("valid_latency", out_valid, 1);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got 0 expected 1");
        end
        if (lit_m >= 0) begin
            check("lit_mean", mean, lit_m);
            check("lit_var", res_var, lit_v);
        end
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_mean  = -1;
        exp_var   = -1;
        check("valid_after_hs", out_valid, 0);
        check("busy_after_hs", busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_mean", mean, 0);
        check("rst_var", res_var, 0);
        rst = 1'b0;
        @(negedge clk);

        // Constant vector, then alternating extremes with and without compression.
        fill_const(8, 130);
        run_vec(8, 32, 0, 1'b0, 0, 1'b0, 130, 0);
        fill_alt();
        run_vec(8, 32, 0, 1'b0, 0, 1'b0, 127, 16383);
        fill_alt();
        run_vec(8, 32, 2, 1'b0, 0, 1'b0, 127, 15623);

        // Bursty input and a stalled consumer.
        fill_const(8, 130);
        run_vec(8, 32, 0, 1'b1, 5, 1'b0, 130, 0);

        // Reset in the middle of a vector.
        start = 1'b1;
        len   = 9'd8;
        inv_n = 8'd32;
        alpha = 2'd0;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        x        = 8'd130;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", in_ready, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_mean", mean, 0);
        check("midrst_var", res_var, 0);
        @(negedge clk);
        check("midrst_busy_held", busy, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        fill_const(8, 130);
        run_vec(8, 32, 0, 1'b0, 0, 1'b0, 130, 0);

        // Empty vector.
        exp_mean = 0;
        exp_var  = 0;
        start = 1'b1;
        len   = 9'd0;
        inv_n = 8'd32;
        alpha = 2'd1;
        @(negedge clk);
        start = 1'b0;
        check("len0_valid", out_valid, 1);
        check("len0_mean", mean, 0);
        check("len0_var", res_var, 0);
        check("len0_ready", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_mean  = -1;
        exp_var   = -1;
        check("len0_done", out_valid, 0);

        // Start pulse while accumulating must be ignored.
        fill_const(8, 130);
        run_vec(8, 32, 0, 1'b0, 0, 1'b1, 130, 0);

        // Saturation of both results.
        fill_const(8, 255);
        run_vec(8, 255, 0, 1'b0, 0, 1'b0, 255, 65535);

        // Oversized length clamps to the maximum.
        vec.delete();
        for (int k = 0; k < 256; k++) vec.push_back($urandom_range(0, 255));
        run_vec(300, 1, 1, 1'b0, 0, 1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
